// File: rtl/edge_gen_pkg.sv
// Shared definitions for the edge pulse generator.
//   edge_gen_state_t : FSM states (level x hold/stable)
//   MIN_HOLD_DEFAULT : default minimum hold in cycles
//   timer_width()    : bit width of the hold down-counter
package edge_gen_pkg;

    typedef enum logic [1:0] {
        LOW_STABLE  = 2'd0,
        LOW_HOLD    = 2'd1,
        HIGH_HOLD   = 2'd2,
        HIGH_STABLE = 2'd3
    } edge_gen_state_t;

    localparam int MIN_HOLD_DEFAULT = 3;

    function automatic int timer_width(input int min_hold);
        return $clog2(min_hold + 1);
    endfunction

endpackage

// File: rtl/hold_timer.sv
// Loadable hold down-counter.
//   clk, rst_n : clock and synchronous active-low reset
//   load       : start a new hold (takes priority over counting)
//   expire     : high during the cycle whose closing edge ends the hold
//   active     : hold running and not yet at its expiry cycle
// After a load at edge k the counter reaches zero after edge k+MIN_HOLD-1,
// so expire marks edge k+MIN_HOLD as the first edge allowed to transition.
module hold_timer
    import edge_gen_pkg::*;
#(
    parameter int MIN_HOLD = MIN_HOLD_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire,
    output logic active
);

    localparam int W = timer_width(MIN_HOLD);
    localparam logic [W-1:0] LOAD_VAL = W'(MIN_HOLD - 1);

    logic [W-1:0] count;
    logic         running;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count   <= '0;
            running <= 1'b0;
        end else if (load) begin
            count   <= LOAD_VAL;
            running <= 1'b1;
        end else if (running) begin
            if (count == '0) begin
                running <= 1'b0;
            end else begin
                count <= count - 1'b1;
            end
        end
    end

    assign expire = running && (count == '0);
    assign active = running && (count != '0);

endmodule

// File: rtl/edge_pulse_generator.sv
// Turns one-cycle rise/fall request pulses into a level output that holds
// each level for at least MIN_HOLD cycles. Requests inside a hold are parked
// in a one-deep pending slot and applied when the hold expires.
//   clk, rst_n  : clock and synchronous active-low reset
//   rise_req    : request out_sig high
//   fall_req    : request out_sig low (both together = conflict, ignored)
//   out_sig     : registered level output
//   busy        : a request at the next edge would be deferred
//   pending     : a deferred request is held
//   overrun     : pulse, a deferred request replaced/cancelled a pending one
//   conflict    : pulse, rise_req and fall_req were high together
//   edge_count  : number of out_sig transitions (wrapping)
module edge_pulse_generator
    import edge_gen_pkg::*;
#(
    parameter int MIN_HOLD = MIN_HOLD_DEFAULT,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             rise_req,
    input  logic             fall_req,
    output logic             out_sig,
    output logic             busy,
    output logic             pending,
    output logic             overrun,
    output logic             conflict,
    output logic [CNT_W-1:0] edge_count
);

    edge_gen_state_t state;
    logic            pend_level;

    logic both_req;
    logic req_valid;
    logic req_level;
    logic in_hold;
    logic free_edge;
    logic target_level;
    logic do_toggle;
    logic timer_expire;
    logic timer_active;

    hold_timer #(
        .MIN_HOLD (MIN_HOLD)
    ) u_hold_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (do_toggle),
        .expire (timer_expire),
        .active (timer_active)
    );

    always_comb begin
        both_req  = rise_req & fall_req;
        req_valid = rise_req ^ fall_req;
        req_level = rise_req;
        in_hold   = (state == LOW_HOLD) || (state == HIGH_HOLD);
        // The expiry edge behaves like a stable-state edge.
        free_edge = !in_hold || timer_expire;
        // A fresh request beats the parked one; otherwise pending decides.
        if (req_valid) begin
            target_level = req_level;
        end else if (pending) begin
            target_level = pend_level;
        end else begin
            target_level = out_sig;
        end
        do_toggle = free_edge && (target_level != out_sig);
    end

    assign busy = in_hold && timer_active;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= LOW_STABLE;
            out_sig    <= 1'b0;
            pending    <= 1'b0;
            pend_level <= 1'b0;
            overrun    <= 1'b0;
            conflict   <= 1'b0;
            edge_count <= '0;
        end else begin
            conflict <= both_req;
            overrun  <= 1'b0;
            if (do_toggle) begin
                out_sig    <= ~out_sig;
                state      <= out_sig ? LOW_HOLD : HIGH_HOLD;
                pending    <= 1'b0;
                edge_count <= edge_count + 1'b1;
            end else if (free_edge) begin
                pending <= 1'b0;
                state   <= out_sig ? HIGH_STABLE : LOW_STABLE;
            end else if (req_valid) begin
                overrun <= pending;
                if (req_level != out_sig) begin
                    pending    <= 1'b1;
                    pend_level <= req_level;
                end else begin
                    pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_edge_pulse_generator.sv
module tb_edge_pulse_generator;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rise_req = 1'b0;
    logic fall_req = 1'b0;

    logic       o0, b0, p0, ov0, c0;
    logic [7:0] n0;
    logic       o1, b1, p1, ov1, c1;
    logic [1:0] n1;
    logic       o2, b2, p2, ov2, c2;
    logic [7:0] n2;

    int errors = 0;
    int checks = 0;
    int edge_n = 0;

    always #5 clk = ~clk;

    edge_pulse_generator #(.MIN_HOLD(3), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rise_req(rise_req), .fall_req(fall_req),
        .out_sig(o0), .busy(b0), .pending(p0), .overrun(ov0),
        .conflict(c0), .edge_count(n0));

    edge_pulse_generator #(.MIN_HOLD(3), .CNT_W(2)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .rise_req(rise_req), .fall_req(fall_req),
        .out_sig(o1), .busy(b1), .pending(p1), .overrun(ov1),
        .conflict(c1), .edge_count(n1));

    edge_pulse_generator #(.MIN_HOLD(1), .CNT_W(8)) dut_h1 (
        .clk(clk), .rst_n(rst_n), .rise_req(rise_req), .fall_req(fall_req),
        .out_sig(o2), .busy(b2), .pending(p2), .overrun(ov2),
        .conflict(c2), .edge_count(n2));

    // Reference model: keeps the edge index of the last transition and
    // decides from its age whether a request applies now or is parked.
    int m_hold  [2] = '{3, 1};
    int m_level [2];
    int m_have  [2];
    int m_last  [2];
    int m_pend  [2];
    int m_plvl  [2];
    int m_cnt   [2];
    int m_ovr   [2];
    int m_cfl   [2];

    function automatic int m_busy(input int i);
        return (m_have[i] != 0 && (edge_n - m_last[i]) <= m_hold[i] - 2) ? 1 : 0;
    endfunction

    task automatic model_step(input logic r, input logic f, input logic rn);
        for (int i = 0; i < 2; i++) begin
            if (!rn) begin
                m_level[i] = 0; m_have[i] = 0; m_last[i] = 0; m_pend[i] = 0;
                m_plvl[i] = 0; m_cnt[i] = 0; m_ovr[i] = 0; m_cfl[i] = 0;
            end else begin
                int  age;
                int  tgt;
                bit  valid;
                int  rl;
                valid    = (r != f);
                rl       = r ? 1 : 0;
                m_cfl[i] = (r && f) ? 1 : 0;
                m_ovr[i] = 0;
                age      = edge_n - m_last[i];
                if (m_have[i] == 0 || age >= m_hold[i]) begin
                    tgt = valid ? rl : (m_pend[i] != 0 ? m_plvl[i] : m_level[i]);
                    m_pend[i] = 0;
                    if (tgt != m_level[i]) begin
                        m_level[i] = tgt;
                        m_have[i]  = 1;
                        m_last[i]  = edge_n;
                        m_cnt[i]   = m_cnt[i] + 1;
                    end
                end else if (valid) begin
                    m_ovr[i] = m_pend[i];
                    if (rl != m_level[i]) begin
                        m_pend[i] = 1;
                        m_plvl[i] = rl;
                    end else begin
                        m_pend[i] = 0;
                    end
                end
            end
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, edge_n, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic f, input logic rn);
        rise_req = r;
        fall_req = f;
        rst_n    = rn;
        @(posedge clk);
        edge_n++;
        #1;
        model_step(r, f, rn);
        chk("out_h3",      int'(o0),  m_level[0]);
        chk("busy_h3",     int'(b0),  m_busy(0));
        chk("pending_h3",  int'(p0),  m_pend[0]);
        chk("overrun_h3",  int'(ov0), m_ovr[0]);
        chk("conflict_h3", int'(c0),  m_cfl[0]);
        chk("count_h3",    int'(n0),  m_cnt[0] % 256);
        chk("count_w2",    int'(n1),  m_cnt[0] % 4);
        chk("out_w2",      int'(o1),  m_level[0]);
        chk("out_h1",      int'(o2),  m_level[1]);
        chk("busy_h1",     int'(b2),  0);
        chk("pending_h1",  int'(p2),  0);
        chk("overrun_h1",  int'(ov2), 0);
        chk("conflict_h1", int'(c2),  m_cfl[1]);
        chk("count_h1",    int'(n2),  m_cnt[1] % 256);
        $display("edge %0d rst_n=%0b rise=%0b fall=%0b | out=%0b busy=%0b pend=%0b ovr=%0b cfl=%0b cnt=%0d | h1 out=%0b cnt=%0d",
                 edge_n, rn, r, f, o0, b0, p0, ov0, c0, n0, o2, n2);
    endtask

    int wrap_exp [5] = '{1, 2, 3, 0, 1};

    initial begin
        // Reset values and first request
        step(0, 0, 0);
        step(0, 0, 0);
        chk("rst_out", int'(o0), 0);
        chk("rst_cnt", int'(n0), 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        chk("first_rise_out", int'(o0), 1);
        chk("first_rise_cnt", int'(n0), 1);

        // Deferral
        step(0, 0, 0);
        step(1, 0, 1);
        chk("defer_busy0", int'(b0), 1);
        step(0, 1, 1);
        chk("defer_pending", int'(p0), 1);
        chk("defer_busy1", int'(b0), 1);
        chk("defer_held", int'(o0), 1);
        step(0, 0, 1);
        chk("defer_busy2", int'(b0), 0);
        step(0, 0, 1);
        chk("defer_applied", int'(o0), 0);
        chk("defer_cnt", int'(n0), 2);

        // Latest wins and overrun
        step(0, 0, 0);
        step(1, 0, 1);
        step(0, 1, 1);
        step(1, 0, 1);
        chk("ovr_pulse", int'(ov0), 1);
        chk("ovr_pending", int'(p0), 0);
        step(0, 0, 1);
        chk("ovr_out", int'(o0), 1);
        chk("ovr_pulse_gone", int'(ov0), 0);
        step(0, 1, 1);
        chk("ovr_stable_immediate", int'(o0), 0);

        // Conflict in low-stable
        step(0, 0, 0);
        step(1, 1, 1);
        chk("cfl_pulse", int'(c0), 1);
        chk("cfl_out", int'(o0), 0);
        chk("cfl_cnt", int'(n0), 0);
        step(0, 0, 1);
        chk("cfl_pulse_gone", int'(c0), 0);

        // Wrap of a 2-bit counter
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step((i % 2) == 0, (i % 2) == 1, 1);
            chk("wrap_seq", int'(n1), wrap_exp[i]);
            step(0, 0, 1);
            step(0, 0, 1);
        end

        // Reset mid-hold drops pending
        step(0, 0, 0);
        step(1, 0, 1);
        step(0, 1, 1);
        step(0, 0, 0);
        chk("rst_mid_out", int'(o0), 0);
        chk("rst_mid_pend", int'(p0), 0);
        chk("rst_mid_busy", int'(b0), 0);
        step(0, 0, 1);
        chk("rst_mid_no_edge", int'(o0), 0);
        chk("rst_mid_cnt", int'(n0), 0);

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            int sel;
            sel = $urandom_range(0, 99);
            if (sel < 2)       step(0, 0, 0);
            else if (sel < 42) step(0, 0, 1);
            else if (sel < 66) step(1, 0, 1);
            else if (sel < 90) step(0, 1, 1);
            else               step(1, 1, 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/edge_pulse_generator.md
# edge_pulse_generator

Transmit-side counterpart of the input edge detector. It accepts one-cycle rise/fall request pulses and drives a clean level output. Each level is held for at least `MIN_HOLD` cycles so a downstream 2-flop-synchronised edge detector sees every transition. Requests arriving during a hold are deferred through a one-deep pending slot, and the block reports conflicts, overruns and a running transition count.

## Interface
- `MIN_HOLD`, 3: minimum cycles `out_sig` stays at a level after any transition; legal range ≥1.
- `CNT_W`, 8: width of `edge_count`.
- `clk` input 1: single clock; all logic on posedge.
- `rst_n` input 1: reset, synchronous, active-low.
- `rise_req` input 1: one-cycle request to drive `out_sig` high.
- `fall_req` input 1: one-cycle request to drive `out_sig` low.
- `out_sig` output 1: registered level output.
- `busy` output 1: high when a request sampled at the next edge would be deferred.
- `pending` output 1: deferred request held.
- `overrun` output 1: one-cycle pulse when a deferred request overwrites an existing pending one.
- `conflict` output 1: one-cycle pulse when `rise_req` and `fall_req` are sampled high together.
- `edge_count` output CNT_W: number of `out_sig` transitions, wraps modulo 2^CNT_W.

## Operation
- FSM states: `LOW_STABLE`, `LOW_HOLD`, `HIGH_HOLD`, `HIGH_STABLE`.
- **Reset** (`rst_n`=0 at an edge): the following values are forced.
  - state `LOW_STABLE`; `out_sig`=0, `busy`=0, `pending`=0, `overrun`=0, `conflict`=0, `edge_count`=0.
  - Hold timer cleared, pending target dropped.
  - Applies mid-hold too; no deferred edge survives reset.
- **Request decode:** `req` = rise-only or fall-only. Both high means no request, and `conflict` pulses.
- **Stable state:**
  - Request for the opposite level: toggle `out_sig`, load the hold timer, go to the matching `*_HOLD` state, increment `edge_count`.
  - Request for the current level: ignored, no flag.
- **Hold state:**
  - Opposite-level request: store it in pending, target = opposite level.
  - Same-level request: clear `pending`; latest target wins.
  - Any request arriving while `pending`=1 pulses `overrun` for one cycle, whether it overwrites or cancels.
- **Hold expiry:**
  - `pending`=1: toggle `out_sig`, reload the timer, enter the opposite `*_HOLD`, clear `pending`, increment `edge_count`.
  - `pending`=0: enter the `*_STABLE` state.
- A request sampled on the expiry edge is treated as in the stable state. It combines with `pending`, and the latest request wins.
- `edge_count` wraps silently from 2^CNT_W−1 to 0.

## Timing
- A request sampled at edge k in a stable state gives `out_sig` updated after edge k (1-cycle latency, registered).
- After a transition at edge k, `out_sig` is constant through edge k+MIN_HOLD−1. The earliest next transition is at edge k+MIN_HOLD.
- A deferred request is applied exactly at edge k+MIN_HOLD.
- `busy` is high after edges k … k+MIN_HOLD−2. With `MIN_HOLD`=1, `busy` is never high and there is no deferral.
- `overrun` and `conflict` are registered. Each is high for exactly the one cycle after the offending edge.
- `edge_count` updates on the same edge as `out_sig`.

## Structure
- Package `edge_gen_pkg`:
  - state enum `edge_gen_state_t`;
  - `MIN_HOLD_DEFAULT`=3;
  - function for hold-timer width: `$clog2(MIN_HOLD+1)`.
- Sub-module `hold_timer`:
  - loadable down-counter with `load`, `expire`, `active` outputs, parameterised by `MIN_HOLD`, same clock and reset.
- The top level contains the FSM, the pending register, the flag registers and `edge_count`. Expected size is about 150–250 lines.

## Test plan
Unless noted, all cases use `MIN_HOLD`=3 and `CNT_W`=8.
- **Reset values:** hold `rst_n`=0 for 2 edges, then release → all outputs 0. `rise_req` at edge 5 → `out_sig`=1 after edge 5, `edge_count`=1.
- **Deferral:**
  - `rise_req` at edge 10, `fall_req` at edge 11 → `pending`=1 after 11, `busy`=1 after edges 10–11.
  - `out_sig`=0 after edge 13, `edge_count`=2.
- **Latest-wins and overrun:** `rise_req` at 10, `fall_req` at 11, `rise_req` at 12 → `overrun`=1 for the cycle after 12, `pending`=0, `out_sig` stays 1, state `HIGH_STABLE` after 13.
- **Conflict:** `rise_req`=`fall_req`=1 at edge 20 while low-stable → `conflict` pulse, `out_sig` stays 0, `edge_count` unchanged.
- **Wrap:** `CNT_W`=2, 5 alternating accepted requests spaced ≥3 cycles apart → `edge_count` sequence 1, 2, 3, 0, 1.
- **Reset mid-hold:**
  - `rise_req` at 30, `fall_req` at 31, `rst_n`=0 at edge 32 → all outputs 0 after 32.
  - No transition at 33; `pending` lost.
